// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: lane width, 5x5xW state type, forward chi and the
// 32-entry row inverse table derived from it.
package keccak_pkg;

  localparam int W = 64;

  typedef logic [4:0][4:0][W-1:0] state_t;   // [i][j][z]
  typedef logic [31:0][4:0]       lut_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chi_inv_state_e;

  function automatic logic [4:0] chi_row(input logic [4:0] x);
    logic [4:0] y;
    for (int i = 0; i < 5; i++) begin
      y[i] = x[i] ^ (~x[(i + 1) % 5] & x[(i + 2) % 5]);
    end
    return y;
  endfunction

  // Chi is a bijection on 5 bits, so scattering every preimage into its image
  // slot fills all 32 entries exactly once.
  function automatic lut_t gen_chi_inv_lut();
    lut_t lut;
    lut = '0;
    for (int v = 0; v < 32; v++) begin
      lut[chi_row(5'(v))] = 5'(v);
    end
    return lut;
  endfunction

  localparam lut_t CHI_INV_LUT = gen_chi_inv_lut();

  function automatic state_t chi_state(input state_t x);
    state_t     y;
    logic [4:0] row;
    y = '0;
    for (int j = 0; j < 5; j++) begin
      for (int z = 0; z < W; z++) begin
        for (int i = 0; i < 5; i++) row[i] = x[i][j][z];
        row = chi_row(row);
        for (int i = 0; i < 5; i++) y[i][j][z] = row[i];
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/keccak_chi_inv_iter_if.sv
// Valid/ready input and output channels of the iterative inverse chi block,
// plus the self-check flag.
interface keccak_chi_inv_iter_if;
  import keccak_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t in_y;
  logic   out_valid;
  logic   out_ready;
  state_t out_x;
  logic   chk_err;

  modport master (
    output in_valid, in_y, out_ready,
    input  in_ready, out_valid, out_x, chk_err
  );

  modport slave (
    input  in_valid, in_y, out_ready,
    output in_ready, out_valid, out_x, chk_err
  );

endinterface

// File: rtl/keccak_chi_inv_iter_row.sv
// Combinational inverse of one 5-bit chi row (bit i of the row is lane i).
module keccak_chi_inv_row
  import keccak_pkg::*;
(
  input  logic [4:0] y_i,
  output logic [4:0] x_o
);

  assign x_o = CHI_INV_LUT[y_i];

endmodule

// File: rtl/keccak_chi_inv_iter.sv
// Iterative inverse chi: one plane j per cycle over five RUN cycles.
// Optional forward-chi self-check on DONE entry: define KECCAK_CHI_INV_CHECK_EN.
module keccak_chi_inv_iter
  import keccak_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  keccak_chi_inv_iter_if.slave bus
);

  chi_inv_state_e   st_q, st_d;
  logic [2:0]       cnt_q, cnt_d;
  state_t           src_q, src_d;
  state_t           res_q, res_d;
  logic [W-1:0][4:0] row_in;
  logic [W-1:0][4:0] row_out;

  // Plane select: gather row z of plane cnt from the captured state.
  always_comb begin
    row_in = '0;
    for (int z = 0; z < W; z++) begin
      for (int i = 0; i < 5; i++) begin
        row_in[z][i] = src_q[i][cnt_q][z];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_row
      keccak_chi_inv_row u_row (
        .y_i (row_in[gi]),
        .x_o (row_out[gi])
      );
    end
  endgenerate

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    src_d = src_q;
    res_d = res_q;
    unique case (st_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          src_d = bus.in_y;
          cnt_d = 3'd0;
          st_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int z = 0; z < W; z++) begin
          for (int i = 0; i < 5; i++) begin
            res_d[i][cnt_q][z] = row_out[z][i];
          end
        end
        if (cnt_q == 3'd4) begin
          cnt_d = 3'd0;
          st_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ST_IDLE;
      cnt_q <= 3'd0;
      src_q <= '0;
      res_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      src_q <= src_d;
      res_q <= res_d;
    end
  end

  assign bus.in_ready  = (st_q == ST_IDLE);
  assign bus.out_valid = (st_q == ST_DONE);
  assign bus.out_x     = res_q;

`ifdef KECCAK_CHI_INV_CHECK_EN
  logic chk_q, chk_d;

  // Compare against the completed result (res_d) on the edge that enters DONE.
  always_comb begin
    chk_d = 1'b0;
    if (st_q == ST_RUN && cnt_q == 3'd4) begin
      chk_d = (chi_state(res_d) != src_q);
    end else if (st_q == ST_DONE && st_d == ST_DONE) begin
      chk_d = chk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_q <= 1'b0;
    else        chk_q <= chk_d;
  end

  assign bus.chk_err = chk_q;
`else
  assign bus.chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_keccak_chi_inv_iter.sv
// Scoreboard bench for keccak_chi_inv_iter: directed and random chi(x) vectors,
// output backpressure, mid-RUN reset and (optionally) a corrupted-LUT self-check.
module tb_keccak_chi_inv_iter;
  import keccak_pkg::*;

  typedef struct {
    state_t x;
    logic   chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  keccak_chi_inv_iter_if bus ();

  keccak_chi_inv_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic state_t fchi(input state_t x);
    state_t y;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int z = 0; z < W; z++)
          y[i][j][z] = x[i][j][z] ^ (~x[(i + 1) % 5][j][z] & x[(i + 2) % 5][j][z]);
    return y;
  endfunction

  function automatic string lane_diff(input state_t got, input state_t exp);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        if (got[i][j] !== exp[i][j])
          return $sformatf("lane[%0d][%0d] got=%h exp=%h", i, j, got[i][j], exp[i][j]);
    return "equal";
  endfunction

  task automatic check(input string name, input logic ok, input string detail);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Monitor: compare each output handshake against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1'b0, "out_valid=1 with empty scoreboard, required none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_x", bus.out_x === e.x, lane_diff(bus.out_x, e.x));
        check("chk_err", bus.chk_err === e.chk,
              $sformatf("got=%b exp=%b", bus.chk_err, e.chk));
        $display("TXN %0d out_x[0][0]=%h chk_err=%b", txn, bus.out_x[0][0], bus.chk_err);
        txn++;
      end
    end
  end

  // Drive one state; returns #1 after the accept edge.
  task automatic send(input state_t y, input state_t xe, input logic ce);
    int n;
    sb.push_back('{x: xe, chk: ce});
    bus.in_y     = y;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      check("accept_timeout", 1'b0, "in_ready never rose, required 1");
      void'(sb.pop_back());
    end else begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_y     = '1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 1'b0, $sformatf("pending=%0d required 0", sb.size()));
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    state_t y, x;
    int     n;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_y      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_in_ready",  bus.in_ready === 1'b1,  $sformatf("got=%b exp=1", bus.in_ready));
    check("rst_out_valid", bus.out_valid === 1'b0, $sformatf("got=%b exp=0", bus.out_valid));
    check("rst_out_x",     bus.out_x === '0,       lane_diff(bus.out_x, '0));
    check("rst_chk_err",   bus.chk_err === 1'b0,   $sformatf("got=%b exp=0", bus.chk_err));

    // All-zero state, with accept-to-valid latency.
    send('0, '0, 1'b0);
    wait_valid(n);
    check("latency", n == 5, $sformatf("got=%0d cycles exp=5", n));
    drain();

    // All-ones rows are a fixed point.
    send('1, '1, 1'b0);
    drain();

    // Row 01001 (y0,y3) inverts to 00001 (x0).
    y = '0; y[0][2][7] = 1'b1; y[3][2][7] = 1'b1;
    x = '0; x[0][2][7] = 1'b1;
    send(y, x, 1'b0);
    drain();

    // Backpressure: result held, no new input accepted.
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) x[i][j] = {$urandom, $urandom};
    bus.out_ready = 1'b0;
    send(fchi(x), x, 1'b0);
    wait_valid(n);
    for (int k = 0; k < 3; k++) begin
      check("hold_out_valid", bus.out_valid === 1'b1, $sformatf("got=%b exp=1", bus.out_valid));
      check("hold_in_ready",  bus.in_ready === 1'b0,  $sformatf("got=%b exp=0", bus.in_ready));
      check("hold_out_x",     bus.out_x === x,        lane_diff(bus.out_x, x));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    drain();

    for (int t = 0; t < 100; t++) begin
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) x[i][j] = {$urandom, $urandom};
      send(fchi(x), x, 1'b0);
      drain();
    end

    // Reset in the third RUN cycle discards the transaction.
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) x[i][j] = {$urandom, $urandom};
    send(fchi(x), x, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    check("mid_rst_out_valid", bus.out_valid === 1'b0, $sformatf("got=%b exp=0", bus.out_valid));
    check("mid_rst_out_x",     bus.out_x === '0,       lane_diff(bus.out_x, '0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", bus.in_ready === 1'b1, $sformatf("got=%b exp=1", bus.in_ready));
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid !== 1'b0) n++;
      @(posedge clk); #1;
    end
    check("post_rst_no_valid", n == 0, $sformatf("out_valid high for %0d cycles, exp 0", n));
    send(fchi(x), x, 1'b0);
    drain();

`ifdef KECCAK_CHI_INV_CHECK_EN
    // Corrupted row inverse for z=0: every plane gets row 11111 there.
    force dut.g_row[0].u_row.x_o = 5'h1f;
    x = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) x[i][j][0] = 1'b1;
    bus.out_ready = 1'b0;
    send('0, x, 1'b1);
    wait_valid(n);
    for (int k = 0; k < 3; k++) begin
      check("chk_err_hold", bus.chk_err === 1'b1, $sformatf("got=%b exp=1", bus.chk_err));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    drain();
    release dut.g_row[0].u_row.x_o;
    check("chk_err_clear", bus.chk_err === 1'b0, $sformatf("got=%b exp=0", bus.chk_err));
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) x[i][j] = {$urandom, $urandom};
    send(fchi(x), x, 1'b0);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
